// File: rtl/scr1_tapc_seq.sv
// JTAG TAP sequencer: 1149.1 FSM, IR, decode, BYPASS/IDCODE, TDO mux.
// Define SCR1_TAPC_IDCODE_EN to build in the IDCODE register.
module scr1_tapc_seq #(
    parameter int unsigned         IR_WIDTH     = 5,
    parameter logic [31:0]         IDCODE_VALUE = 32'h1000_0001,
    parameter logic [IR_WIDTH-1:0] OPC_IDCODE   = 'h01,
    parameter logic [IR_WIDTH-1:0] OPC_DTMCS    = 'h10,
    parameter logic [IR_WIDTH-1:0] OPC_DMI      = 'h11
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tms,
    input  logic                tdi,
    output logic                tdo,
    output logic                tdo_en,
    output logic                tap_rst_n_sync,
    output logic                fsm_dr_capture,
    output logic                fsm_dr_shift,
    output logic                fsm_dr_update,
    output logic                dr_sel_dtmcs,
    output logic                dr_sel_dmi,
    input  logic                dtmcs_serial,
    input  logic                dmi_serial,
    output logic [IR_WIDTH-1:0] ir_value
);

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } state_t;

`ifdef SCR1_TAPC_IDCODE_EN
    localparam logic IDCODE_EN = 1'b1;
`else
    localparam logic IDCODE_EN = 1'b0;
`endif
    localparam logic [IR_WIDTH-1:0] RST_OPC = IDCODE_EN ? OPC_IDCODE : '1;
    localparam logic [IR_WIDTH-1:0] IR_CAP  = {{(IR_WIDTH-1){1'b0}}, 1'b1};

    state_t              state;
    state_t              state_nx;
    logic [IR_WIDTH-1:0] ir_sh;
    logic [IR_WIDTH-1:0] ir_reg;
    logic                bypass;
    logic                idcode_tdo;
    logic                sel_idcode;
    logic                sel_bypass;
    logic                tdo_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= TLR;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            TLR:    state_nx = tms ? TLR    : RTI;
            RTI:    state_nx = tms ? SEL_DR : RTI;
            SEL_DR: state_nx = tms ? SEL_IR : CAP_DR;
            CAP_DR: state_nx = tms ? EX1_DR : SH_DR;
            SH_DR:  state_nx = tms ? EX1_DR : SH_DR;
            EX1_DR: state_nx = tms ? UPD_DR : PAU_DR;
            PAU_DR: state_nx = tms ? EX2_DR : PAU_DR;
            EX2_DR: state_nx = tms ? UPD_DR : SH_DR;
            UPD_DR: state_nx = tms ? SEL_DR : RTI;
            SEL_IR: state_nx = tms ? TLR    : CAP_IR;
            CAP_IR: state_nx = tms ? EX1_IR : SH_IR;
            SH_IR:  state_nx = tms ? EX1_IR : SH_IR;
            EX1_IR: state_nx = tms ? UPD_IR : PAU_IR;
            PAU_IR: state_nx = tms ? EX2_IR : PAU_IR;
            EX2_IR: state_nx = tms ? UPD_IR : SH_IR;
            UPD_IR: state_nx = tms ? SEL_DR : RTI;
        endcase
    end

    assign tap_rst_n_sync = (state != TLR);
    assign fsm_dr_capture = (state == CAP_DR);
    assign fsm_dr_shift   = (state == SH_DR);
    assign fsm_dr_update  = (state == UPD_DR);

    // TLR forces the reset opcode at both edges, ahead of the negedge reload
    assign ir_value = (state == TLR) ? RST_OPC : ir_reg;

    always_comb begin
        dr_sel_dtmcs = 1'b0;
        dr_sel_dmi   = 1'b0;
        sel_idcode   = 1'b0;
        sel_bypass   = 1'b0;
        unique case (1'b1)
            (ir_value == OPC_DTMCS):                dr_sel_dtmcs = 1'b1;
            (ir_value == OPC_DMI):                  dr_sel_dmi   = 1'b1;
            (IDCODE_EN && ir_value == OPC_IDCODE):  sel_idcode   = 1'b1;
            default:                                sel_bypass   = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_sh  <= '0;
            bypass <= 1'b0;
        end else begin
            if (state == CAP_IR) begin
                ir_sh <= IR_CAP;
            end else if (state == SH_IR) begin
                ir_sh <= {tdi, ir_sh[IR_WIDTH-1:1]};
            end
            if (sel_bypass && fsm_dr_capture) begin
                bypass <= 1'b0;
            end else if (sel_bypass && fsm_dr_shift) begin
                bypass <= tdi;
            end
        end
    end

`ifdef SCR1_TAPC_IDCODE_EN
    logic [31:0] idcode_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idcode_sh <= IDCODE_VALUE;
        end else if (sel_idcode && fsm_dr_capture) begin
            idcode_sh <= IDCODE_VALUE;
        end else if (sel_idcode && fsm_dr_shift) begin
            idcode_sh <= {tdi, idcode_sh[31:1]};
        end
    end

    assign idcode_tdo = idcode_sh[0];
`else
    // no register: IDCODE is never selected, so this term stays 0
    assign idcode_tdo = sel_idcode & IDCODE_VALUE[0];
`endif

    always_comb begin
        tdo_nx = 1'b0;
        if (state == SH_IR) begin
            tdo_nx = ir_sh[0];
        end else if (state == SH_DR) begin
            tdo_nx = (dr_sel_dtmcs & dtmcs_serial)
                   | (dr_sel_dmi   & dmi_serial)
                   | (sel_idcode   & idcode_tdo)
                   | (sel_bypass   & bypass);
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
            ir_reg <= RST_OPC;
        end else begin
            tdo    <= tdo_nx;
            tdo_en <= (state == SH_IR) || (state == SH_DR);
            if (state == TLR) begin
                ir_reg <= RST_OPC;
            end else if (state == UPD_IR) begin
                ir_reg <= ir_sh;
            end
        end
    end

endmodule

// File: tb/tb_scr1_tapc_seq.sv
// Scoreboard bench for scr1_tapc_seq: random IR/DR scans vs a
// queue-based scan model; a negedge monitor checks every TDO bit.
module tb_scr1_tapc_seq;

    localparam int IRW = 5;
    localparam logic [31:0] IDV = 32'h1000_0001;
    localparam logic [IRW-1:0] OP_ID  = 5'h01;
    localparam logic [IRW-1:0] OP_DTM = 5'h10;
    localparam logic [IRW-1:0] OP_DMI = 5'h11;
`ifdef SCR1_TAPC_IDCODE_EN
    localparam bit ID_EN = 1'b1;
`else
    localparam bit ID_EN = 1'b0;
`endif
    localparam logic [IRW-1:0] RST_OPC = ID_EN ? OP_ID : 5'h1F;

    logic clk, rst_n, tms, tdi, dtmcs_serial, dmi_serial;
    logic tdo, tdo_en, tap_rst_n_sync;
    logic fsm_dr_capture, fsm_dr_shift, fsm_dr_update;
    logic dr_sel_dtmcs, dr_sel_dmi;
    logic [IRW-1:0] ir_value;

    int errors = 0;
    int checks = 0;
    int upd_cnt = 0;
    int mode = 0;
    bit exp_q[$];
    bit dr_q[$];
    logic [IRW-1:0] cur_ir;
    logic [31:0] idv;

    scr1_tapc_seq dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .tms            (tms),
        .tdi            (tdi),
        .tdo            (tdo),
        .tdo_en         (tdo_en),
        .tap_rst_n_sync (tap_rst_n_sync),
        .fsm_dr_capture (fsm_dr_capture),
        .fsm_dr_shift   (fsm_dr_shift),
        .fsm_dr_update  (fsm_dr_update),
        .dr_sel_dtmcs   (dr_sel_dtmcs),
        .dr_sel_dmi     (dr_sel_dmi),
        .dtmcs_serial   (dtmcs_serial),
        .dmi_serial     (dmi_serial),
        .ir_value       (ir_value)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // monitor: pops one expected bit for every TDO-enabled negedge
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                chk("sel_onehot", 32'(dr_sel_dtmcs & dr_sel_dmi), 0);
                if (fsm_dr_update) upd_cnt++;
                if (tdo_en) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tdo_unexpected: tdo_en=1 got bit %0b, required no bit", tdo);
                    end else begin
                        chk("tdo", 32'(tdo), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    // one TCK: drive inputs, update model, wait to just after negedge
    task automatic tick(input logic t, input logic d, input bit smp,
                        input bit shf);
        tms = t;
        tdi = d;
        dtmcs_serial = 1'($urandom);
        dmi_serial = 1'($urandom);
        if (shf && mode == 0) begin
            void'(dr_q.pop_front());
            dr_q.push_back(d);
        end
        if (smp) begin
            if (mode == 1) exp_q.push_back(dtmcs_serial);
            else if (mode == 2) exp_q.push_back(dmi_serial);
            else exp_q.push_back(dr_q[0]);
        end
        @(posedge clk);
        @(negedge clk);
        #2;
    endtask

    task automatic capture(input bit is_ir);
        dr_q.delete();
        mode = 0;
        if (is_ir) begin
            dr_q.push_back(1'b1);
            for (int i = 1; i < IRW; i++) dr_q.push_back(1'b0);
        end else if (cur_ir == OP_DTM) begin
            mode = 1;
        end else if (cur_ir == OP_DMI) begin
            mode = 2;
        end else if (ID_EN && cur_ir == OP_ID) begin
            for (int i = 0; i < 32; i++) dr_q.push_back(idv[i]);
        end else begin
            dr_q.push_back(1'b0);
        end
    endtask

    task automatic scan(input bit is_ir, input int n,
                        input logic [63:0] data, input int pause_at);
        logic [IRW-1:0] old_ir;
        old_ir = cur_ir;
        upd_cnt = 0;
        tick(1, 0, 0, 0);
        if (is_ir) tick(1, 0, 0, 0);
        capture(is_ir);
        tick(0, 0, 0, 0);
        chk("capture_strobe", 32'(fsm_dr_capture), 32'(!is_ir));
        tick(0, 0, 1, 0);
        for (int j = 0; j < n; j++) begin
            if (j == n - 1) begin
                tick(1, data[j], 0, 1);
            end else if (j == pause_at) begin
                tick(1, data[j], 0, 1);
                tick(0, 0, 0, 0);
                chk("pause_shift", 32'(fsm_dr_shift), 0);
                chk("pause_tdo_en", 32'(tdo_en), 0);
                tick(0, 0, 0, 0);
                tick(1, 0, 0, 0);
                tick(0, 0, 1, 0);
            end else begin
                tick(0, data[j], 1, 1);
            end
        end
        if (is_ir) chk("ir_before_upd", 32'(ir_value), 32'(old_ir));
        tick(1, 0, 0, 0);
        if (is_ir) begin
            cur_ir = data[IRW-1:0];
            chk("ir_value", 32'(ir_value), 32'(cur_ir));
            chk("sel_dtmcs", 32'(dr_sel_dtmcs), 32'(cur_ir == OP_DTM));
            chk("sel_dmi", 32'(dr_sel_dmi), 32'(cur_ir == OP_DMI));
        end
        tick(0, 0, 0, 0);
        chk("update_pulses", 32'(upd_cnt), is_ir ? 0 : 1);
        chk("scan_drained", 32'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    task automatic to_tlr(input string tag);
        for (int i = 1; i <= 5; i++) begin
            tick(1, 0, 0, 0);
            if (i == 4) chk({tag, "_not_yet"}, 32'(tap_rst_n_sync), 1);
        end
        chk({tag, "_tlr"}, 32'(tap_rst_n_sync), 0);
        chk({tag, "_ir"}, 32'(ir_value), 32'(RST_OPC));
        cur_ir = RST_OPC;
        chk({tag, "_drained"}, 32'(exp_q.size()), 0);
        exp_q.delete();
        tick(0, 0, 0, 0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        cur_ir = RST_OPC;
        tick(0, 0, 0, 0);
    endtask

    initial begin
        logic [IRW-1:0] op;
        int n;
        int p;
        idv = IDV;
        rst_n = 1'b0;
        tms = 1'b1;
        tdi = 1'b0;
        dtmcs_serial = 1'b0;
        dmi_serial = 1'b0;
        cur_ir = RST_OPC;
        #3;
        chk("rst_tdo", 32'(tdo), 0);
        chk("rst_tdo_en", 32'(tdo_en), 0);
        chk("rst_sync", 32'(tap_rst_n_sync), 0);
        chk("rst_strobes", 32'({fsm_dr_capture, fsm_dr_shift, fsm_dr_update}), 0);
        chk("rst_sels", 32'({dr_sel_dtmcs, dr_sel_dmi}), 0);
        chk("rst_ir", 32'(ir_value), 32'(RST_OPC));
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        tick(0, 0, 0, 0);
        chk("rti_sync", 32'(tap_rst_n_sync), 1);

        tick(1, 0, 0, 0);
        capture(0);
        tick(0, 0, 0, 0);
        tick(0, 0, 1, 0);
        chk("in_sh_dr", 32'(fsm_dr_shift), 1);
        rst_n = 1'b0;
        #1;
        chk("async_tdo_en", 32'(tdo_en), 0);
        chk("async_tdo", 32'(tdo), 0);
        chk("async_sync", 32'(tap_rst_n_sync), 0);
        chk("async_shift", 32'(fsm_dr_shift), 0);
        chk("async_ir", 32'(ir_value), 32'(RST_OPC));
        exp_q.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        tick(0, 0, 0, 0);
        chk("rel_sync", 32'(tap_rst_n_sync), 1);
        chk("rel_tdo_en", 32'(tdo_en), 0);
        chk("rel_ir", 32'(ir_value), 32'(RST_OPC));
        chk("rel_strobes", 32'({fsm_dr_capture, fsm_dr_shift, fsm_dr_update}), 0);

        scan(1, IRW, 64'h11, -1);
        apply_reset();
        scan(0, 32, 64'h0, -1);
        scan(1, IRW, 64'h1F, -1);
        scan(0, 5, 64'b01011, -1);

        tick(1, 0, 0, 0);
        capture(0);
        tick(0, 0, 0, 0);
        tick(0, 0, 1, 0);
        to_tlr("from_sh_dr");
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        capture(1);
        tick(0, 0, 0, 0);
        tick(0, 0, 1, 0);
        tick(1, 1, 0, 1);
        tick(0, 0, 0, 0);
        to_tlr("from_pau_ir");

        scan(1, IRW, 64'h10, -1);
        scan(0, 32, {$urandom, $urandom}, 10);

        for (int it = 0; it < 25; it++) begin
            case ($urandom_range(0, 4))
                0: op = OP_DTM;
                1: op = OP_DMI;
                2: op = OP_ID;
                3: op = 5'h1F;
                default: op = IRW'($urandom);
            endcase
            p = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, IRW - 2)) : -1;
            scan(1, IRW, 64'(op), p);
            n = int'($urandom_range(1, 40));
            p = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, n - 1)) : -1;
            scan(0, n, {$urandom, $urandom}, p);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scr1_tapc_seq.md
# scr1_tapc_seq

JTAG TAP sequencer for the debug transport: the IEEE 1149.1 16-state TAP FSM, instruction register, instruction decode and TDO multiplexer. It drives the select, capture, shift and update strobes of the TAPC data registers (DTMCS, DMI) and owns the built-in BYPASS and IDCODE registers. It sits between the JTAG pins and the DR instances inside the TAP controller.

## Interface
Parameters:
- IR_WIDTH, 5, instruction register width in bits (≥2)
- IDCODE_VALUE, 32'h1000_0001, IDCODE register content; bit 0 must be 1
- OPC_IDCODE, 5'h01, IDCODE opcode
- OPC_DTMCS, 5'h10, DTMCS opcode
- OPC_DMI, 5'h11, DMI opcode
- BYPASS opcode is fixed at all-ones.

Ports:
- clk  in  1  TCK
- rst_n  in  1  TRST; asynchronous reset, active-low
- tms  in  1  mode select, sampled on posedge clk
- tdi  in  1  serial data in, sampled on posedge clk
- tdo  out  1  serial data out, updated on negedge clk
- tdo_en  out  1  TDO output enable, updated on negedge clk
- tap_rst_n_sync  out  1  low while FSM is in Test-Logic-Reset; feeds DR rst_n_sync
- fsm_dr_capture / fsm_dr_shift / fsm_dr_update  out  1 each  high while FSM is in Capture-DR / Shift-DR / Update-DR
- dr_sel_dtmcs, dr_sel_dmi  out  1 each  one-hot DR selects from the current instruction
- dtmcs_serial, dmi_serial  in  1 each  dout_serial of the external DRs
- ir_value  out  IR_WIDTH  current (updated) instruction

## Operation
- FSM states: TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR, plus the IR equivalents SEL_IR through UPD_IR. Transitions on posedge clk per 1149.1:
  - TLR: tms=1 stays, tms=0 goes to RTI.
  - RTI: tms=1 goes to SEL_DR.
  - SEL_DR: tms=1 goes to SEL_IR, tms=0 goes to CAP_DR.
  - SEL_IR: tms=1 goes to TLR, tms=0 goes to CAP_IR.
  - CAP: tms=0 goes to SH, tms=1 goes to EX1.
  - SH: tms=1 goes to EX1.
  - EX1: tms=0 goes to PAU, tms=1 goes to UPD.
  - PAU: tms=1 goes to EX2.
  - EX2: tms=0 goes to SH, tms=1 goes to UPD.
  - UPD: tms=1 goes to SEL_DR, tms=0 goes to RTI.
- IR shift register:
  - Loads {0…0,2'b01} on posedge in CAP_IR.
  - Shifts {tdi, ir_sh[IR_WIDTH-1:1]} on posedge in SH_IR.
  - ir_value <= ir_sh on negedge in UPD_IR.
- ir_value is IDCODE opcode while in TLR, at both clock edges.
- Decode:
  - OPC_DTMCS selects dr_sel_dtmcs; OPC_DMI selects dr_sel_dmi.
  - Every other opcode selects BYPASS, or IDCODE for OPC_IDCODE.
  - At most one select is high at any time.
- BYPASS: 1-bit register; loads 0 on CAP_DR and tdi on SH_DR when selected.
- IDCODE: 32-bit register; loads IDCODE_VALUE on CAP_DR and shifts LSB-first on SH_DR when selected.
- TDO source:
  - SH_IR selects ir_sh[0].
  - SH_DR selects the serial output of the selected DR.
  - Any other state selects 0.
- tdo_en is high only for the negedge-registered SH_IR/SH_DR states.

## Timing
- Reset values while rst_n=0:
  - state TLR, ir_value IDCODE opcode, ir_sh 0, bypass 0, IDCODE register IDCODE_VALUE
  - tdo 0, tdo_en 0, tap_rst_n_sync 0, all strobes 0
- Reset is asynchronous. Reset mid-shift aborts the scan, and the first posedge after release evaluates from TLR.
- From any state, five posedges with tms=1 reach TLR.
- Strobes and selects are combinational from the state and ir_value, so they are glitch-free relative to posedge.
- The first data bit appears on tdo at the negedge after entry into SH_xR. The last bit is shifted on the posedge leaving SH_xR via tms=1.
- New instruction:
  - dr_sel_* change at the UPD_IR negedge.
  - DRs latch their shadow register on the UPD_DR negedge.
- BYPASS adds exactly 1 TCK delay tdi→tdo.

## Configuration
- SCR1_TAPC_IDCODE_EN defined: IDCODE register is instantiated, and ir_value resets to OPC_IDCODE.
- Macro undefined:
  - No IDCODE register; OPC_IDCODE decodes to BYPASS.
  - ir_value resets to and re-enters TLR as all-ones (BYPASS).
  - A DR scan after reset shifts out a leading 0.

## Test plan
- Assert rst_n=0 in SH_DR, release, then drive tms=0 → state RTI, tdo_en=0, ir_value=5'h01, tap_rst_n_sync low during reset and high after leaving TLR.
- From RTI, shift IR 5'h11 with tms=0 at each posedge → tdo shows captured 1,0,0,0,0; after UPD_IR, dr_sel_dmi=1 and dr_sel_dtmcs=0.
- After reset, DR scan of 32 bits with tdi=0 → tdo sequence equals IDCODE_VALUE LSB-first (32'h1000_0001). With macro off, the same scan shifts out 0 followed by tdi delayed by one bit.
- Load IR 5'h1F, then shift DR pattern 1011 → tdo yields 0,1,1,0,1 (one-cycle delay).
- Drive tms=1 for 5 cycles starting from PAU_IR and from SH_DR → TLR reached on the 5th posedge; ir_value=IDCODE opcode.
- Load IR 5'h10, run a DR scan with pause (SH→EX1→PAU→EX2→SH) → fsm_dr_shift is low during PAU, shifting resumes without bit loss, and fsm_dr_update pulses once.
